// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for a single-port data RAM (async read, sync write); port 0 = pipeline, port 1 = debug.
// Optional starvation guard for port 1 is compiled in with `define ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t            state_q;
  logic              gnt0, gnt1, force1;
  logic              p0_ack_q, p1_ack_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Never force two port-1 grants in a row, so the pipeline always gets the next slot.
  assign force1 = (starve_cnt_q == CNT_MAX) & p1_req & (state_q != OWN1);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p1_req || gnt1)
      starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_MAX)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_guard;
  assign force1       = 1'b0;
  assign unused_guard = ^{state_q, 1'(STARVE_MAX)};
`endif

  assign gnt0     = p0_req & ~force1;
  assign gnt1     = p1_req & ~gnt0;
  assign p0_stall = p0_req & ~gnt0;

  always_comb begin
    mem_a  = '0;
    mem_d  = '0;
    mem_we = 1'b0;
    if (gnt0) begin
      mem_a  = p0_addr;
      mem_d  = p0_wdata;
      mem_we = p0_we;
    end else if (gnt1) begin
      mem_a  = p1_addr;
      mem_d  = p1_wdata;
      mem_we = p1_we;
    end
    // A write must not reach the RAM while reset is held, even mid-cycle.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      if (gnt0)      state_q <= OWN0;
      else if (gnt1) state_q <= OWN1;
      else           state_q <= IDLE;
      p0_ack_q <= gnt0;
      p1_ack_q <= gnt1;
      if (gnt0 && !p0_we) p0_rdata_q <= mem_spo;
      if (gnt1 && !p1_we) p1_rdata_q <= mem_spo;
    end
  end

  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural RAM; honours `ARB_STARVE_GUARD_EN when defined.
module tb_data_mem_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_req = 1'b0, p0_we = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ack, p0_stall;
  logic              p1_req = 1'b0, p1_we = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [DATA_W-1:0] p1_wdata = '0;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ack;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_spo;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
  );

  always #5 clk = ~clk;

  // RAM: async read, write on posedge
  logic [DATA_W-1:0] ram [0:255] = '{default: '0};
  assign mem_spo = ram[mem_a];
  always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;

  typedef struct {
    bit                port;
    logic [DATA_W-1:0] data;
  } sb_t;

  sb_t               sb[$];
  logic [DATA_W-1:0] model_mem [0:255] = '{default: '0};
  logic [DATA_W-1:0] m_rd0 = '0, m_rd1 = '0;
  int                m_cnt = 0, m_state = 0;
  int                n_vec = 0, n_err = 0;
  int                n_p1ack = 0, n_stall = 0, stall_cyc = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle, predicts the grant and checks the result after the edge.
  task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
    logic f1, g0, g1;
    sb_t  e;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    f1 = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    f1 = (m_cnt == STARVE_MAX) && r1 && (m_state != 2);
`endif
    g0 = r0 && !f1;
    g1 = r1 && !g0;
    cyc++;
    #2;
    chk("p0_stall", p0_stall, r0 && !g0);
    chk("mem_we", mem_we, g0 ? w0 : (g1 ? w1 : 1'b0));
    if (g0 || g1) chk("mem_a", mem_a, g0 ? a0 : a1);
    if (p0_stall) begin n_stall++; stall_cyc = cyc; end
    if (g0) begin
      e.port = 1'b0; e.data = w0 ? m_rd0 : model_mem[a0]; m_rd0 = e.data; sb.push_back(e);
      if (w0) model_mem[a0] = d0;
    end else if (g1) begin
      e.port = 1'b1; e.data = w1 ? m_rd1 : model_mem[a1]; m_rd1 = e.data; sb.push_back(e);
      if (w1) model_mem[a1] = d1;
    end
`ifdef ARB_STARVE_GUARD_EN
    if (!r1 || g1) m_cnt = 0;
    else if (m_cnt != STARVE_MAX) m_cnt++;
`endif
    m_state = g0 ? 1 : (g1 ? 2 : 0);
    @(posedge clk); #1;
    chk("p0_ack", p0_ack, g0);
    chk("p1_ack", p1_ack, g1);
    if (p1_ack) n_p1ack++;
    if (p0_ack || p1_ack) begin
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ack_port", p1_ack, e.port);
        chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
      end
    end else begin
      chk("sb_pending", sb.size(), 0);
      sb.delete();
    end
    chk("p0_rdata_hold", p0_rdata, m_rd0);
    chk("p1_rdata_hold", p1_rdata, m_rd1);
    chk("state", 32'(dut.state_q), m_state);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a write pending on port 0: nothing may reach the RAM.
    p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_p1_ack", p1_ack, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_state", 32'(dut.state_q), 0);
    @(posedge clk); #1;
    chk("rst_ram10", ram[8'h10], 0);
    rst = 0;

    // 1: p0 write then read same address, plus a held identical read
    step(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0);
    step(1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0);
    step(1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    idle();

    // 2: p1 only, read address 3 after loading it
    step(0, 0, 8'h00, 32'h0, 1, 1, 8'h03, 32'h12345678);
    step(0, 0, 8'h00, 32'h0, 1, 0, 8'h03, 32'h0);
    chk("t2_rdata", p1_rdata, 32'h12345678);
    idle();

    // 3: simultaneous requests; p0 reads old value, p1 write lands next
    step(1, 0, 8'h20, 32'h0, 1, 1, 8'h20, 32'h5);
    chk("t3_old", p0_rdata, 32'h0);
    step(0, 0, 8'h00, 32'h0, 1, 1, 8'h20, 32'h5);
    step(1, 0, 8'h20, 32'h0, 0, 0, 8'h00, 32'h0);
    chk("t3_new", p0_rdata, 32'h5);
    idle();

    // 4: p0 held continuously, p1 held; guard decides whether p1 ever wins
    n_p1ack = 0; n_stall = 0; stall_cyc = 0; cyc = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 8'h10, 32'h0, 1, 0, 8'h03, 32'h0);
`ifdef ARB_STARVE_GUARD_EN
    chk("t4_p1_acks", n_p1ack, 1);
    chk("t4_stalls", n_stall, 1);
    chk("t4_stall_cycle", stall_cyc, STARVE_MAX + 1);
`else
    chk("t4_p1_acks", n_p1ack, 0);
    chk("t4_stalls", n_stall, 0);
`endif
    idle();

    // 5: reset mid-cycle during a p1 write while a p0 ack is in flight
    step(1, 1, 8'h05, 32'h00000055, 0, 0, 8'h00, 32'h0);
    step(1, 0, 8'h05, 32'h0,        0, 0, 8'h00, 32'h0);
    p0_req = 0; p1_req = 1; p1_we = 1; p1_addr = 8'h05; p1_wdata = 32'hAA;
    #2;
    chk("t5_we_pre", mem_we, 1);
    rst = 1;
    #1;
    chk("t5_p0_ack", p0_ack, 0);
    chk("t5_p1_ack", p1_ack, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_p0_rdata", p0_rdata, 0);
    @(posedge clk); #1;
    chk("t5_ram5", ram[8'h05], model_mem[8'h05]);
    chk("t5_state", 32'(dut.state_q), 0);
    p1_req = 0; p1_we = 0;
    sb.delete(); m_rd0 = '0; m_rd1 = '0; m_cnt = 0; m_state = 0;
    @(posedge clk); #1;
    rst = 0;
    step(1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0);
    chk("t5_prior", p0_rdata, 32'h00000055);

    // 6: ten idle cycles, rdata registers hold
    step(0, 0, 8'h00, 32'h0, 1, 0, 8'h03, 32'h0);
    for (int i = 0; i < 10; i++) idle();
    chk("t6_p0_hold", p0_rdata, 32'h00000055);
    chk("t6_p1_hold", p1_rdata, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
